// File: rtl/unit_fetch_control_pkg.sv
// Types and helpers shared by the fetch-control unit and its redirect counter.
package unit_fetch_control_pkg;

`include "parameters.vh"

  localparam int unsigned ADDR_W = `ADDRWIDTH;

  typedef enum logic {
    ST_RUN    = `STATE_RUN,
    ST_HALTED = `STATE_HALTED
  } fetch_state_e;

  // Control-flow resolution of the instruction currently in ID.
  function automatic logic redirect_taken(input logic jump, input logic beq,
                                          input logic bne, input logic is_equal);
    return jump | (beq & is_equal) | (bne & ~is_equal);
  endfunction

endpackage

// File: rtl/parameters.vh
// Shared fetch-unit constants: address width and fetch-state encodings.
`ifndef UNIT_FETCH_CONTROL_PARAMETERS_VH
`define UNIT_FETCH_CONTROL_PARAMETERS_VH

`define ADDRWIDTH   16
`define STATE_RUN    1'b0
`define STATE_HALTED 1'b1

`endif

// File: rtl/unit_counter.sv
// Free-running wrapping event counter; counts cycles with inc_i high.
module unit_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/unit_fetch_control.sv
// IF-stage PC sequencing: sequential fetch, branch/jump redirect, stall hold and HALT.
module unit_fetch_control
  import unit_fetch_control_pkg::*;
#(
  parameter int unsigned NB_COUNT = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enable_i,
  input  logic                stall_i,
  input  logic                halt_i,
  input  logic                beq_i,
  input  logic                bne_i,
  input  logic                jump_i,
  input  logic                is_equal_i,
  input  logic [ADDR_W-1:0]   branch_address_i,
  input  logic [ADDR_W-1:0]   jump_address_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ADDR_W-1:0]   pc_next_o,
  output logic                flush_ifid_o,
  output logic                halted_o,
  output logic [NB_COUNT-1:0] redirect_count_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              advance;
  logic              taken;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // HALT wins over a redirect; a stalled or frozen pipe holds and never flushes.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_ifid_o = 1'b0;
    taken        = redirect_taken(jump_i, beq_i, bne_i, is_equal_i);
    advance      = enable_i & ~stall_i & (state_q == ST_RUN);
    if (advance) begin
      if (halt_i) begin
        state_d = ST_HALTED;
      end else if (taken) begin
        flush_ifid_o = reset_n_i;
        pc_d         = jump_i ? jump_address_i : branch_address_i;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  unit_counter #(
    .WIDTH (NB_COUNT)
  ) u_redirect_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (flush_ifid_o),
    .count_o   (redirect_count_o)
  );

  assign pc_o      = pc_q;
  assign pc_next_o = pc_q + ADDR_W'(1);
  assign halted_o  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_unit_fetch_control.sv
// Self-checking bench for unit_fetch_control against a cycle-level behavioural model.
module tb_unit_fetch_control;
  import unit_fetch_control_pkg::*;

  localparam int AW     = ADDR_W;
  localparam int NBC    = 8;
  localparam int PC_MOD = 1 << AW;
  localparam int CN_MOD = 1 << NBC;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0, stall = 1'b0, halt = 1'b0;
  logic           beq = 1'b0, bne = 1'b0, jump = 1'b0, eq = 1'b0;
  logic [AW-1:0]  baddr = '0, jaddr = '0;
  logic [AW-1:0]  pc, pc_next;
  logic           flush, halted;
  logic [NBC-1:0] count;

  int compared = 0;
  int mismatched = 0;

  // Model state: fetch address, halted flag and redirect count as plain integers.
  int m_pc = 0;
  int m_cnt = 0;
  bit m_halt = 1'b0;

  unit_fetch_control #(.NB_COUNT(NBC)) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .enable_i         (enable),
    .stall_i          (stall),
    .halt_i           (halt),
    .beq_i            (beq),
    .bne_i            (bne),
    .jump_i           (jump),
    .is_equal_i       (eq),
    .branch_address_i (baddr),
    .jump_address_i   (jaddr),
    .pc_o             (pc),
    .pc_next_o        (pc_next),
    .flush_ifid_o     (flush),
    .halted_o         (halted),
    .redirect_count_o (count)
  );

  always #5 clk = ~clk;

  function automatic bit m_taken();
    return jump || (beq && eq) || (bne && !eq);
  endfunction

  function automatic bit m_flush();
    return rst_n && enable && !stall && !m_halt && m_taken() && !halt;
  endfunction

  task automatic model_edge();
    if (rst_n && enable && !stall && !m_halt) begin
      if (halt) m_halt = 1'b1;
      else if (m_taken()) begin
        m_pc  = jump ? int'(jaddr) : int'(baddr);
        m_cnt = (m_cnt + 1) % CN_MOD;
      end else m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit st, input bit h, input bit b, input bit n,
                       input bit j, input bit e, input int ba, input int ja);
    enable = en; stall = st; halt = h; beq = b; bne = n; jump = j; eq = e;
    baddr = AW'(ba); jaddr = AW'(ja);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_halt = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 'h77);
    compared++;
    if (flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %0b want 0", flush); end
    compared++;
    if (pc !== '0 || halted !== 1'b0 || count !== '0) begin
      mismatched++; $display("FAIL reset_state: pc=%0h halted=%0b count=%0h want 0/0/0", pc, halted, count);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_halt = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      compared++;
      if (flush !== 1'b0) begin mismatched++; $display("FAIL seq_flush[%0d]: got %0b want 0", i, flush); end
      tick();
      compared++;
      if (pc !== AW'(i) || count !== '0) begin
        mismatched++; $display("FAIL seq_pc[%0d]: pc=%0h count=%0h want %0h/0", i, pc, count, i);
      end
    end
    compared++;
    if (pc_next !== AW'(5)) begin mismatched++; $display("FAIL seq_pc_next: got %0h want 5", pc_next); end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 1, 'h20, 'h99);
    compared++;
    if (pc !== AW'(5) || flush !== 1'b1) begin
      mismatched++; $display("FAIL beq_taken_flush: pc=%0h flush=%0b want 5/1", pc, flush);
    end
    tick();
    compared++;
    if (pc !== AW'('h20) || count !== NBC'(1)) begin
      mismatched++; $display("FAIL beq_taken_pc: pc=%0h count=%0h want 20/1", pc, count);
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0, 5);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 'h20, 0);
    compared++;
    if (flush !== 1'b0) begin mismatched++; $display("FAIL beq_not_taken_flush: got %0b want 0", flush); end
    tick();
    compared++;
    if (pc !== AW'(6) || count !== NBC'(m_cnt)) begin
      mismatched++; $display("FAIL beq_not_taken_pc: pc=%0h count=%0h want 6/%0h", pc, count, m_cnt);
    end
  endtask

  task automatic test_jump_priority();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8);
    tick();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8);
    tick();
    drive(1, 0, 0, 1, 0, 1, 1, 'h30, 'h40);
    tick();
    compared++;
    if (pc !== AW'('h40) || count !== NBC'(2)) begin
      mismatched++; $display("FAIL jump_priority: pc=%0h count=%0h want 40/2", pc, count);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] held;
    held = pc;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 1, 0, 0, 'h123, 0);
      compared++;
      if (flush !== 1'b0) begin mismatched++; $display("FAIL stall_flush[%0d]: got %0b want 0", i, flush); end
      tick();
      compared++;
      if (pc !== held) begin mismatched++; $display("FAIL stall_hold[%0d]: pc=%0h want %0h", i, pc, held); end
    end
    drive(1, 0, 0, 0, 1, 0, 0, 'h123, 0);
    compared++;
    if (flush !== 1'b1) begin mismatched++; $display("FAIL stall_release_flush: got %0b want 1", flush); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (pc !== AW'('h123) || flush !== 1'b0 || count !== NBC'(m_cnt)) begin
      mismatched++; $display("FAIL stall_release_pc: pc=%0h flush=%0b count=%0h want 123/0/%0h", pc, flush, count, m_cnt);
    end
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 'h10);
    tick();
    drive(1, 0, 1, 0, 0, 1, 0, 0, 'h55);
    compared++;
    if (flush !== 1'b0) begin mismatched++; $display("FAIL halt_flush: got %0b want 0", flush); end
    tick();
    compared++;
    if (halted !== 1'b1 || pc !== AW'('h10)) begin
      mismatched++; $display("FAIL halt_enter: halted=%0b pc=%0h want 1/10", halted, pc);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, $urandom_range(0, 1), 1, 0, 1, 1, $urandom, $urandom);
      compared++;
      if (flush !== 1'b0 || pc !== AW'('h10) || halted !== 1'b1 || count !== NBC'(m_cnt)) begin
        mismatched++; $display("FAIL halt_hold[%0d]: flush=%0b pc=%0h halted=%0b want 0/10/1", i, flush, pc, halted);
      end
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if (pc !== '0 || halted !== 1'b0 || count !== '0) begin
      mismatched++; $display("FAIL halt_async_reset: pc=%0h halted=%0b count=%0h want 0/0/0", pc, halted, count);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_halt = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    compared++;
    if (pc !== AW'(1)) begin mismatched++; $display("FAIL post_reset_fetch: pc=%0h want 1", pc); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ones;
    ones = '1;
    drive(1, 0, 0, 0, 0, 1, 0, 0, int'(ones));
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (pc !== ones || pc_next !== '0) begin
      mismatched++; $display("FAIL pc_all_ones: pc=%0h pc_next=%0h want %0h/0", pc, pc_next, ones);
    end
    tick();
    compared++;
    if (pc !== '0) begin mismatched++; $display("FAIL pc_wrap: pc=%0h want 0", pc); end
    apply_reset();
    for (int i = 1; i <= CN_MOD; i++) begin
      drive(1, 0, 0, $urandom_range(0, 1), 0, 1, $urandom_range(0, 1), $urandom, $urandom);
      tick();
      if (i == CN_MOD - 1) begin
        compared++;
        if (count !== '1) begin mismatched++; $display("FAIL count_all_ones: got %0h want %0h", count, CN_MOD - 1); end
      end
    end
    compared++;
    if (count !== '0) begin mismatched++; $display("FAIL count_wrap: got %0h want 0", count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && ($urandom_range(0, 7) == 0)) apply_reset();
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1), $urandom, $urandom);
      compared++;
      if (flush !== m_flush()) begin
        mismatched++; $display("FAIL rand_flush[%0d]: got %0b want %0b", i, flush, m_flush());
      end
      tick();
      compared++;
      if (pc !== AW'(m_pc) || pc_next !== AW'((m_pc + 1) % PC_MOD) || halted !== m_halt || count !== NBC'(m_cnt)) begin
        mismatched++;
        $display("FAIL rand_state[%0d]: pc=%0h next=%0h halted=%0b count=%0h want %0h/%0h/%0b/%0h",
                 i, pc, pc_next, halted, count, m_pc, (m_pc + 1) % PC_MOD, m_halt, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_halt();
    test_wrap();
    apply_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
